// File: rtl/uart_rx_if.sv
// Parallel-side and serial-side signals of the UART receiver.
// The master drives the serial line and configuration; the slave (receiver) returns the byte.
interface uart_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              Rx_clk;
    logic              Rx_in;
    logic              Par_En;
    logic              Par_Odd;
    logic [DATA_W-1:0] Data;
    logic              Data_Valid;
    logic              Parity_Err;
    logic              Frame_Err;
    logic              Busy;

    modport master (
        output Rx_clk, Rx_in, Par_En, Par_Odd,
        input  Data, Data_Valid, Parity_Err, Frame_Err, Busy
    );

    modport slave (
        input  Rx_clk, Rx_in, Par_En, Par_Odd,
        output Data, Data_Valid, Parity_Err, Frame_Err, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, DATA_W data bits LSB first, optional parity, one stop bit.
// Samples at bit centre using the OVS-per-bit tick from the baud generator.
module uart_rx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OVS    = 16
) (
    input  logic    clk,
    input  logic    reset,
    uart_rx_if.slave bus
);
    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [TW-1:0] HalfM1  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] FullM1  = TW'(OVS - 1);
    localparam logic [BW-1:0] LastBit = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_odd_q, par_odd_d;
    logic                par_bad_q, par_bad_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dv_q, dv_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
    logic                rx_meta_q, rx_s_q;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        par_bad_d = par_bad_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        if (bus.Rx_clk) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d   = StStart;
                        tcnt_d    = '0;
                        par_en_d  = bus.Par_En;
                        par_odd_d = bus.Par_Odd;
                        par_bad_d = 1'b0;
                    end
                end
                StStart: begin
                    if (tcnt_q == HalfM1) begin
                        // A line that is high again at mid start bit was noise.
                        if (!rx_s_q) begin
                            state_d = StData;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tcnt_q == FullM1) begin
                        shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                        tcnt_d  = '0;
                        if (bcnt_q == LastBit) begin
                            state_d = par_en_q ? StParity : StStop;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StParity: begin
                    if (tcnt_q == FullM1) begin
                        par_bad_d = rx_s_q ^ (^shift_q) ^ par_odd_q;
                        tcnt_d    = '0;
                        state_d   = StStop;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tcnt_q == FullM1) begin
                        data_d  = shift_q;
                        ferr_d  = ~rx_s_q;
                        perr_d  = par_en_q & par_bad_q;
                        dv_d    = 1'b1;
                        tcnt_d  = '0;
                        state_d = StIdle;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bad_q <= 1'b0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= bus.Rx_in;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_bad_q <= par_bad_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.Data       = data_q;
    assign bus.Data_Valid = dv_q;
    assign bus.Parity_Err = perr_q;
    assign bus.Frame_Err  = ferr_q;
    assign bus.Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames with hand-computed expectations,
// a negedge monitor pops the expected queue on every Data_Valid.
module tb_uart_rx;
    localparam int BIT_CLKS = 64;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   dv_count;
    bit   busy_seen;
    bit   prev_dv;
    exp_t sb[$];
    int   dv_times[$];

    uart_rx_if #(.DATA_W(8)) u_if ();

    uart_rx #(
        .DATA_W(8),
        .OVS   (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One tick every 4 clk: 64 clk per bit at OVS=16.
    initial begin
        logic [1:0] ph;
        ph = 2'd0;
        u_if.Rx_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = ph + 2'd1;
            u_if.Rx_clk = (ph == 2'd3);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every Data_Valid against the scoreboard head.
    initial begin
        prev_dv   = 1'b0;
        busy_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (u_if.Busy) busy_seen = 1'b1;
            if (u_if.Data_Valid === 1'b1) begin
                dv_count++;
                dv_times.push_back(cyc);
                check("dv_single_cycle", 32'(prev_dv), 32'd0);
                check("busy_low_with_dv", 32'(u_if.Busy), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_dv", 32'(u_if.Data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data", 32'(u_if.Data), 32'(e.d));
                    check("parity_err", 32'(u_if.Parity_Err), 32'(e.pe));
                    check("frame_err", 32'(u_if.Frame_Err), 32'(e.fe));
                end
            end
            prev_dv = u_if.Data_Valid;
        end
    end

    task automatic drive_bit(input logic b);
        u_if.Rx_in = b;
        repeat (BIT_CLKS) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(sbit);
        u_if.Rx_in = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        u_if.Rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(u_if.Data), 32'd0);
        check({tag, "_dv"}, 32'(u_if.Data_Valid), 32'd0);
        check({tag, "_perr"}, 32'(u_if.Parity_Err), 32'd0);
        check({tag, "_ferr"}, 32'(u_if.Frame_Err), 32'd0);
        check({tag, "_busy"}, 32'(u_if.Busy), 32'd0);
    endtask

    initial begin
        int   dvc;
        exp_t e;
        checks = 0;
        errors = 0;
        cyc = 0;
        dv_count = 0;
        reset = 1'b0;
        u_if.Rx_in = 1'b1;
        u_if.Par_En = 1'b0;
        u_if.Par_Odd = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        idle_bits(1);

        // 0xA5, no parity.
        e = '{d: 8'hA5, pe: 1'b0, fe: 1'b0};
        sb.push_back(e);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle_bits(2);
        wait_drain("drain_a5");

        // Even parity: 0x3C has four ones, so the correct parity bit is 0.
        u_if.Par_En = 1'b1;
        u_if.Par_Odd = 1'b0;
        e = '{d: 8'h3C, pe: 1'b0, fe: 1'b0};
        sb.push_back(e);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle_bits(2);
        e = '{d: 8'h3C, pe: 1'b1, fe: 1'b0};
        sb.push_back(e);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        wait_drain("drain_parity");
        u_if.Par_En = 1'b0;
        idle_bits(1);

        // Framing error: stop bit low.
        e = '{d: 8'h81, pe: 1'b0, fe: 1'b1};
        sb.push_back(e);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        idle_bits(3);
        wait_drain("drain_ferr");

        // Start-bit glitch of 3 ticks.
        dvc = dv_count;
        busy_seen = 1'b0;
        u_if.Rx_in = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        u_if.Rx_in = 1'b1;
        repeat (128) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_pulsed", 32'(busy_seen), 32'd1);
        check("glitch_no_dv", 32'(dv_count), 32'(dvc));
        check("glitch_data_held", 32'(u_if.Data), 32'h81);
        check("glitch_busy_low", 32'(u_if.Busy), 32'd0);
        check("glitch_ferr_held", 32'(u_if.Frame_Err), 32'd1);

        // Reset in the middle of data bit 4 of a 0x33 frame.
        dvc = dv_count;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        u_if.Rx_in = 1'b1;
        repeat (32) @(posedge clk);
        @(negedge clk);
        check("midframe_busy", 32'(u_if.Busy), 32'd1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset_hold");
        reset = 1'b1;
        idle_bits(2);
        check("abort_no_dv", 32'(dv_count), 32'(dvc));
        e = '{d: 8'h5A, pe: 1'b0, fe: 1'b0};
        sb.push_back(e);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle_bits(2);
        wait_drain("drain_5a");

        // Back-to-back frames with no idle gap.
        e = '{d: 8'h00, pe: 1'b0, fe: 1'b0};
        sb.push_back(e);
        e = '{d: 8'hFF, pe: 1'b0, fe: 1'b0};
        sb.push_back(e);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle_bits(2);
        wait_drain("drain_b2b");
        check("total_dv_count", 32'(dv_count), 32'd7);
        if (dv_times.size() >= 2) begin
            check("b2b_spacing", 32'(dv_times[dv_times.size()-1] - dv_times[dv_times.size()-2]),
                  32'd640);
        end else begin
            check("b2b_dv_seen", 32'(dv_times.size()), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
